// File: rtl/trim_rx_if.sv
// Trim-code serial link bundle: generator-side serial lines plus the receiver's
// committed-code outputs.
interface trim_rx_if #(
    parameter int unsigned WIDTH = 12
);
    logic             SCLK;
    logic             SDIN;
    logic [WIDTH-1:0] TRIM_OUT;
    logic             TRIM_VALID;
    logic             FRAME_ERR;
    logic             BUSY;

    modport master (
        output SCLK,
        output SDIN,
        input  TRIM_OUT,
        input  TRIM_VALID,
        input  FRAME_ERR,
        input  BUSY
    );

    modport slave (
        input  SCLK,
        input  SDIN,
        output TRIM_OUT,
        output TRIM_VALID,
        output FRAME_ERR,
        output BUSY
    );
endinterface

// File: rtl/trim_rx.sv
// Serial trim receiver: oversamples SCLK/SDIN in CLK50, deserializes one LSB-first
// code per frame (frames end on an SCLK-idle gap) and holds the last good code.
module trim_rx #(
    parameter int unsigned      WIDTH      = 12,
    parameter int unsigned      GAP_CYCLES = 75000000,
    parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
    input  logic      CLK50,
    input  logic      RST,
    trim_rx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(WIDTH + 1);
    localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic             sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic             sdin_meta_q, sdin_sync_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] trim_q, trim_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic sclk_fall, sclk_edge, gap_term;

    assign sclk_fall = sclk_prev_q & ~sclk_sync_q;
    assign sclk_edge = sclk_prev_q ^ sclk_sync_q;
    assign gap_term  = (gap_q == GAP_TERM) & ~sclk_edge;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        trim_d  = trim_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (sclk_fall) begin
                    shift_d = {sdin_sync_q, shift_q[WIDTH-1:1]};
                    count_d = CNT_ONE;
                    state_d = RECV;
                end
            end
            RECV: begin
                // An edge always beats a coincident gap terminal.
                if (sclk_edge) begin
                    gap_d = '0;
                    if (sclk_fall) begin
                        if (count_q < CNT_FULL) begin
                            shift_d = {sdin_sync_q, shift_q[WIDTH-1:1]};
                        end
                        if (count_q != CNT_OVR) begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end else if (gap_term) begin
                    if (count_q == CNT_FULL) begin
                        trim_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    count_d = '0;
                    shift_d = '0;
                    gap_d   = '0;
                    state_d = IDLE;
                end else if (gap_q != GAP_MAX) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (!RST) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdin_meta_q <= 1'b0;
            sdin_sync_q <= 1'b0;
            state_q     <= IDLE;
            count_q     <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            trim_q      <= RESET_CODE;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_meta_q <= bus.SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            sdin_meta_q <= bus.SDIN;
            sdin_sync_q <= sdin_meta_q;
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            shift_q     <= shift_d;
            trim_q      <= trim_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.TRIM_OUT   = trim_q;
    assign bus.TRIM_VALID = valid_q;
    assign bus.FRAME_ERR  = err_q;
    assign bus.BUSY       = (state_q == RECV);

endmodule
